digitron_source_arbiter: RTL and testbench

//  Shares the single six-digit 7-segment scan driver between three 24-bit hex sources:
//  the live accumulator/counter value (default), key-event messages, and alarm messages.

---
 rtl/digitron_pkg.sv | 28 ++
 rtl/ms_tick_gen.sv | 35 +++
 rtl/digitron_source_arbiter.sv | 140 ++++++++++++++
 tb/tb_digitron_source_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/digitron_pkg.sv
// Shared definitions for the digitron display path.
//   state_e      : display-owner states of the source arbiter
//   GNT_SRC0/1/2 : one-hot grant codes {src2,src1,src0}
//   DIGIT_W      : width of a six-digit hex value
//   grant_of()   : maps an owner state to its one-hot grant code
package digitron_pkg;

  localparam int unsigned DIGIT_W = 24;

  typedef enum logic [1:0] {
    S_LIVE  = 2'd0,
    S_HOLD1 = 2'd1,
    S_HOLD2 = 2'd2
  } state_e;

  localparam logic [2:0] GNT_SRC0 = 3'b001;
  localparam logic [2:0] GNT_SRC1 = 3'b010;
  localparam logic [2:0] GNT_SRC2 = 3'b100;

  function automatic logic [2:0] grant_of(state_e s);
    case (s)
      S_HOLD1: grant_of = GNT_SRC1;
      S_HOLD2: grant_of = GNT_SRC2;
      default: grant_of = GNT_SRC0;
    endcase
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..CLK_DIV-1 and raises tick_o for the one
// cycle in which the count sits at CLK_DIV-1. clr_i restarts the count at 0
// on the next cycle.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous reset, active-high
//   clr_i  : synchronous restart of the count
//   tick_o : one-cycle tick, once per CLK_DIV cycles
module ms_tick_gen #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/digitron_source_arbiter.sv
// Fixed-priority arbiter sharing the six-digit scan driver between the live
// value (Src0), key messages (Src1) and alarm messages (Src2, highest).
// A granted message is held for HOLD_MS ms, then the live value returns.
// Optional feature macro: DIGITRON_BLINK_EN -- blinks the display (Blank_Out)
// with a BLINK_MS half-period while an alarm message is shown.
// Ports:
//   CLK, RST           : clock, synchronous active-high reset
//   Src0_Num           : live value, shown when no message owns the display
//   Src1_Req/Src1_Num  : key message request (level) and value
//   Src2_Req/Src2_Num  : alarm message request (level) and value
//   Src1_Ack/Src2_Ack  : one-cycle accept pulses
//   Grant              : one-hot owner {src2,src1,src0}
//   Hex_SixNum         : value to the scan driver
//   Blank_Out          : 1 = blank all digits
module digitron_source_arbiter
  import digitron_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 50000,
  parameter int unsigned HOLD_MS  = 2000,
  parameter int unsigned BLINK_MS = 250
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [DIGIT_W-1:0] Src0_Num,
  input  logic               Src1_Req,
  input  logic [DIGIT_W-1:0] Src1_Num,
  input  logic               Src2_Req,
  input  logic [DIGIT_W-1:0] Src2_Num,
  output logic               Src1_Ack,
  output logic               Src2_Ack,
  output logic [2:0]         Grant,
  output logic [DIGIT_W-1:0] Hex_SixNum,
  output logic               Blank_Out
);

  localparam int unsigned HOLD_W = $clog2(HOLD_MS + 1);

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DIGIT_W-1:0]  hex_q, hex_d;
  logic [2:0]          gnt_q;
  logic                ack1_q, ack2_q;
  logic                acc1, acc2, expire, tick;

  ms_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i  (CLK),
    .rst_i  (RST),
    .clr_i  (acc1 | acc2),
    .tick_o (tick)
  );

  always_comb begin
    acc1    = 1'b0;
    acc2    = 1'b0;
    state_d = state_q;
    hold_d  = hold_q;
    expire  = (state_q != S_LIVE) && tick && (hold_q == HOLD_W'(1));
    // Src1 waits behind an alarm until that alarm's hold expires.
    if (Src2_Req)                                       acc2 = 1'b1;
    else if (Src1_Req && (state_q != S_HOLD2 || expire)) acc1 = 1'b1;

    if (acc2)        state_d = S_HOLD2;
    else if (acc1)   state_d = S_HOLD1;
    else if (expire) state_d = S_LIVE;

    if (acc1 || acc2)                    hold_d = HOLD_W'(HOLD_MS);
    else if (state_q != S_LIVE && tick)  hold_d = hold_q - HOLD_W'(1);

    if (acc2)                   hex_d = Src2_Num;
    else if (acc1)              hex_d = Src1_Num;
    else if (state_d == S_LIVE) hex_d = Src0_Num;
    else                        hex_d = hex_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_LIVE;
      hold_q  <= '0;
      hex_q   <= '0;
      gnt_q   <= GNT_SRC0;
      ack1_q  <= 1'b0;
      ack2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      hex_q   <= hex_d;
      gnt_q   <= grant_of(state_d);
      ack1_q  <= acc1;
      ack2_q  <= acc2;
    end
  end

  assign Src1_Ack   = ack1_q;
  assign Src2_Ack   = ack2_q;
  assign Grant      = gnt_q;
  assign Hex_SixNum = hex_q;

`ifdef DIGITRON_BLINK_EN
  localparam int unsigned BLINK_W = $clog2(BLINK_MS + 1);

  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               blank_q, blank_d;

  // Blink phase restarts unblanked on every alarm accept; the counter
  // reloads on each phase toggle so the half-period stays BLINK_MS ticks.
  always_comb begin
    blink_d = blink_q;
    blank_d = blank_q;
    if (acc2) begin
      blink_d = BLINK_W'(BLINK_MS);
      blank_d = 1'b0;
    end else if (state_d != S_HOLD2) begin
      blink_d = '0;
      blank_d = 1'b0;
    end else if (tick) begin
      if (blink_q == BLINK_W'(1)) begin
        blink_d = BLINK_W'(BLINK_MS);
        blank_d = ~blank_q;
      end else begin
        blink_d = blink_q - BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      blink_q <= '0;
      blank_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
      blank_q <= blank_d;
    end
  end

  assign Blank_Out = blank_q;
`else
  assign Blank_Out = 1'b0;
`endif

endmodule

// File: tb/tb_digitron_source_arbiter.sv
module tb_digitron_source_arbiter;

  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned HOLD_MS  = 3;
  localparam int unsigned BLINK_MS = 1;
  localparam int          HOLD_CYC = 12;
`ifdef DIGITRON_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic        CLK;
  logic        RST;
  logic [23:0] Src0_Num, Src1_Num, Src2_Num;
  logic        Src1_Req, Src2_Req;
  logic        Src1_Ack, Src2_Ack;
  logic [2:0]  Grant;
  logic [23:0] Hex_SixNum;
  logic        Blank_Out;

  int checks   = 0;
  int failures = 0;

  digitron_source_arbiter #(
    .CLK_DIV(CLK_DIV), .HOLD_MS(HOLD_MS), .BLINK_MS(BLINK_MS)
  ) dut (
    .CLK(CLK), .RST(RST),
    .Src0_Num(Src0_Num),
    .Src1_Req(Src1_Req), .Src1_Num(Src1_Num),
    .Src2_Req(Src2_Req), .Src2_Num(Src2_Num),
    .Src1_Ack(Src1_Ack), .Src2_Ack(Src2_Ack),
    .Grant(Grant), .Hex_SixNum(Hex_SixNum), .Blank_Out(Blank_Out)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // advance one clock and sample just after the edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_live(input string tag, input logic [23:0] val);
    chk({tag, ".gnt"}, 32'(Grant), 32'(3'b001));
    chk({tag, ".hex"}, 32'(Hex_SixNum), 32'(val));
    chk({tag, ".blank"}, 32'(Blank_Out), 32'd0);
  endtask

  // hold cycles first_i..last_i-1 of a message (index 0 is the ack cycle)
  task automatic chk_hold(input string tag, input logic [2:0] gnt, input logic [23:0] val,
                          input int first_i, input int last_i);
    logic exp_blank;
    for (int i = first_i; i < last_i; i++) begin
      step();
      exp_blank = BLINK_ON && (gnt == 3'b100) && (i >= 4) && (i < 8);
      chk($sformatf("%s.gnt%0d", tag, i), 32'(Grant), 32'(gnt));
      chk($sformatf("%s.hex%0d", tag, i), 32'(Hex_SixNum), 32'(val));
      chk($sformatf("%s.ack1_%0d", tag, i), 32'(Src1_Ack), 32'd0);
      chk($sformatf("%s.ack2_%0d", tag, i), 32'(Src2_Ack), 32'd0);
      chk($sformatf("%s.blank%0d", tag, i), 32'(Blank_Out), 32'(exp_blank));
    end
  endtask

  initial begin
    RST = 1'b1;
    Src0_Num = 24'h123456;
    Src1_Req = 1'b0; Src1_Num = 24'h0;
    Src2_Req = 1'b0; Src2_Num = 24'h0;

    // 1: reset values, then live value one cycle after release
    step();
    chk("rst1.hex", 32'(Hex_SixNum), 32'h0);
    chk("rst1.gnt", 32'(Grant), 32'(3'b001));
    step();
    chk("rst2.hex", 32'(Hex_SixNum), 32'h0);
    chk("rst2.gnt", 32'(Grant), 32'(3'b001));
    chk("rst2.acks", 32'({Src2_Ack, Src1_Ack}), 32'd0);
    chk("rst2.blank", 32'(Blank_Out), 32'd0);
    RST = 1'b0;
    step();
    chk_live("rel", 24'h123456);

    // 2: key message held for exactly 12 cycles
    Src1_Req = 1'b1; Src1_Num = 24'h00ABCD;
    step();
    chk("k.ack1", 32'(Src1_Ack), 32'd1);
    chk("k.ack2", 32'(Src2_Ack), 32'd0);
    chk("k.gnt", 32'(Grant), 32'(3'b010));
    chk("k.hex", 32'(Hex_SixNum), 32'h00ABCD);
    Src1_Req = 1'b0;
    chk_hold("k", 3'b010, 24'h00ABCD, 1, HOLD_CYC);
    step();
    chk_live("k.end", 24'h123456);

    // 3: alarm preempts key message in its 5th cycle; key not resumed
    Src1_Req = 1'b1; Src1_Num = 24'h00ABCD;
    step();
    chk("p.ack1", 32'(Src1_Ack), 32'd1);
    Src1_Req = 1'b0;
    chk_hold("p1", 3'b010, 24'h00ABCD, 1, 5);
    Src2_Req = 1'b1; Src2_Num = 24'hEEEEEE;
    step();
    chk("p.ack2", 32'(Src2_Ack), 32'd1);
    chk("p.gnt", 32'(Grant), 32'(3'b100));
    chk("p.hex", 32'(Hex_SixNum), 32'hEEEEEE);
    chk("p.blank0", 32'(Blank_Out), 32'd0);
    Src2_Req = 1'b0;
    chk_hold("p2", 3'b100, 24'hEEEEEE, 1, HOLD_CYC);
    step();
    chk_live("p.end", 24'h123456);

    // 4: key request pending through an alarm hold, granted directly at expiry
    Src2_Req = 1'b1; Src2_Num = 24'hA1A2A3;
    Src1_Req = 1'b1; Src1_Num = 24'h111111;
    step();
    chk("q.ack2", 32'(Src2_Ack), 32'd1);
    chk("q.ack1", 32'(Src1_Ack), 32'd0);
    chk("q.gnt", 32'(Grant), 32'(3'b100));
    chk("q.hex", 32'(Hex_SixNum), 32'hA1A2A3);
    Src2_Req = 1'b0;
    chk_hold("q2", 3'b100, 24'hA1A2A3, 1, HOLD_CYC);
    step();
    chk("q.hand.ack1", 32'(Src1_Ack), 32'd1);
    chk("q.hand.gnt", 32'(Grant), 32'(3'b010));
    chk("q.hand.hex", 32'(Hex_SixNum), 32'h111111);
    chk("q.hand.blank", 32'(Blank_Out), 32'd0);
    Src1_Req = 1'b0;
    chk_hold("q1", 3'b010, 24'h111111, 1, HOLD_CYC);
    step();
    chk_live("q.end", 24'h123456);

    // 5: reset in the 6th alarm cycle; hold does not resume afterwards
    Src2_Req = 1'b1; Src2_Num = 24'h0F0F0F;
    step();
    chk("r.ack2", 32'(Src2_Ack), 32'd1);
    Src2_Req = 1'b0;
    chk_hold("r2", 3'b100, 24'h0F0F0F, 1, 6);
    RST = 1'b1;
    step();
    chk("r.rst.gnt", 32'(Grant), 32'(3'b001));
    chk("r.rst.hex", 32'(Hex_SixNum), 32'h0);
    chk("r.rst.blank", 32'(Blank_Out), 32'd0);
    RST = 1'b0;
    Src0_Num = 24'h654321;
    for (int i = 0; i < HOLD_CYC; i++) begin
      step();
      chk_live($sformatf("r.post%0d", i), 24'h654321);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // run-length guard
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
